// File: rtl/dmem_arbiter.sv
// Two-port fixed-priority arbiter for the shared data memory. Port 1 is promoted after
// STARVE_LIMIT denied cycles. Illegal accesses are answered with err and do not write memory.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [2:0]  p0_type,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [2:0]  p1_type,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [2:0]  mem_load_type,
  output logic [2:0]  mem_store_type,
  input  logic [31:0] mem_rd
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rsp_v_q, rsp_v_d;
  logic       rsp_port_q, rsp_port_d;
  logic       rsp_load_q, rsp_load_d;
  logic       rsp_err_q, rsp_err_d;

  logic        force1, acc0, acc1, accepted, sel_we, err;
  logic [31:0] sel_addr;
  logic [2:0]  sel_type;

  always_comb begin
    force1   = (starve_cnt_q == LIMIT);
    p1_ready = !p0_valid || force1;
    p0_ready = !(p1_valid && force1);
    acc1     = p1_valid && p1_ready;
    acc0     = p0_valid && p0_ready && !acc1;
    accepted = acc0 || acc1;

    // Port 0 drives the memory bus whenever port 1 is not the one being accepted.
    sel_we   = acc1 ? p1_we    : p0_we;
    sel_addr = acc1 ? p1_addr  : p0_addr;
    sel_type = acc1 ? p1_type  : p0_type;
    mem_wd   = acc1 ? p1_wdata : p0_wdata;

    err = 1'b0;
    if (sel_we) begin
      if (sel_type > 3'b010) err = 1'b1;
    end else if (sel_type == 3'b011 || sel_type[2:1] == 2'b11) begin
      err = 1'b1;
    end
    case (sel_type[1:0])
      2'b01:   if (sel_addr[0]) err = 1'b1;
      2'b10:   if (sel_addr[1:0] != 2'b00) err = 1'b1;
      default: ;
    endcase

    mem_addr       = sel_addr;
    mem_store_type = sel_type;
    mem_load_type  = sel_we ? 3'b010 : sel_type;
    mem_we         = accepted && sel_we && !err && !rst;

    starve_cnt_d = 4'd0;
    if (p1_valid && !p1_ready)
      starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 4'd1;

    rsp_v_d    = accepted;
    rsp_port_d = acc1;
    rsp_load_d = !sel_we;
    rsp_err_d  = err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
      rsp_v_q      <= 1'b0;
      rsp_port_q   <= 1'b0;
      rsp_load_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_v_q      <= rsp_v_d;
      rsp_port_q   <= rsp_port_d;
      rsp_load_q   <= rsp_load_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // mem_rd is the registered read of last cycle's address, so it lines up with rsp_*_q.
  always_comb begin
    p0_rsp_valid = rsp_v_q && !rsp_port_q;
    p1_rsp_valid = rsp_v_q && rsp_port_q;
    p0_rsp_err   = p0_rsp_valid && rsp_err_q;
    p1_rsp_err   = p1_rsp_valid && rsp_err_q;
    p0_rsp_rdata = (p0_rsp_valid && rsp_load_q && !rsp_err_q) ? mem_rd : 32'd0;
    p1_rsp_rdata = (p1_rsp_valid && rsp_load_q && !rsp_err_q) ? mem_rd : 32'd0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand sequences for starvation/burst/reset,
// and a randomized phase compared against a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_valid = 0, p0_we = 0, p1_valid = 0, p1_we = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic [2:0]  p0_type = 0, p1_type = 0;
  logic        p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
  logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [2:0]  mem_load_type, mem_store_type;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_type(p0_type), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_type(p1_type), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_load_type(mem_load_type), .mem_store_type(mem_store_type), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] extract(input logic [2:0] t, input logic [7:0] b0, b1, b2, b3);
    case (t)
      3'd0:    return {{24{b0[7]}}, b0};
      3'd1:    return {{16{b1[7]}}, b1, b0};
      3'd2:    return {b3, b2, b1, b0};
      3'd4:    return {24'd0, b0};
      3'd5:    return {16'd0, b1, b0};
      default: return 32'd0;
    endcase
  endfunction

  // Stand-in for Data_Memory: byte array, synchronous write, registered read.
  logic [7:0] env_mem [256];
  always @(posedge clk) begin
    logic [7:0] a;
    a = mem_addr[7:0];
    if (mem_we) begin
      env_mem[a] <= mem_wd[7:0];
      if (mem_store_type != 3'd0) env_mem[8'(a + 1)] <= mem_wd[15:8];
      if (mem_store_type == 3'd2) begin
        env_mem[8'(a + 2)] <= mem_wd[23:16];
        env_mem[8'(a + 3)] <= mem_wd[31:24];
      end
    end
    mem_rd <= extract(mem_load_type, env_mem[a], env_mem[8'(a + 1)],
                      env_mem[8'(a + 2)], env_mem[8'(a + 3)]);
  end

  // Reference model: tracks how long port 1 has waited, a shadow memory, and the one
  // response owed for the previous cycle's grant.
  logic [7:0]  ref_mem [256];
  int          m_wait = 0;
  bit          m_acc0 = 0, m_acc1 = 0, chk_rand = 0;
  bit          m_pv = 0, m_pp = 0, m_pe = 0;
  logic [31:0] m_pd = 0;

  function automatic bit ref_err(input bit we, input logic [2:0] t, input logic [31:0] a);
    int size;
    if (we) begin
      if (t > 3'd2) return 1'b1;
      size = 1 << t;
    end else begin
      if (t == 3'd3 || t == 3'd6 || t == 3'd7) return 1'b1;
      size = 1 << t[1:0];
    end
    return (a % size) != 0;
  endfunction

  always @(negedge clk) begin : model
    bit f1, g0, g1, e, we;
    logic [31:0] a, d;
    logic [2:0]  t;
    int          size;
    if (rst) begin
      m_wait = 0; m_pv = 0; m_acc0 = 0; m_acc1 = 0;
    end else begin
      f1 = (m_wait >= LIM);
      g1 = p1_valid && (!p0_valid || f1);
      g0 = p0_valid && !g1;
      we = g1 ? p1_we : p0_we;
      a  = g1 ? p1_addr : p0_addr;
      d  = g1 ? p1_wdata : p0_wdata;
      t  = g1 ? p1_type : p0_type;
      e  = ref_err(we, t, a);
      if (chk_rand) begin
        chk1("rnd_p0_ready", p0_ready, !p1_valid || !f1);
        chk1("rnd_p1_ready", p1_ready, !p0_valid || f1);
        chk1("rnd_rsp0_v", p0_rsp_valid, m_pv && !m_pp);
        chk1("rnd_rsp1_v", p1_rsp_valid, m_pv && m_pp);
        chk1("rnd_rsp0_err", p0_rsp_err, m_pv && !m_pp && m_pe);
        chk1("rnd_rsp1_err", p1_rsp_err, m_pv && m_pp && m_pe);
        chk32("rnd_rsp0_rdata", p0_rsp_rdata, (m_pv && !m_pp) ? m_pd : 32'd0);
        chk32("rnd_rsp1_rdata", p1_rsp_rdata, (m_pv && m_pp) ? m_pd : 32'd0);
        chk1("rnd_mem_we", mem_we, (g0 || g1) && we && !e);
        if (g0 || g1) begin
          chk32("rnd_mem_addr", mem_addr, a);
          if (we && !e) chk32("rnd_mem_wd", mem_wd, d);
          if (!we) chk32("rnd_mem_lt", {29'd0, mem_load_type}, {29'd0, t});
        end
      end
      m_acc0 = g0;
      m_acc1 = g1;
      m_pv = g0 || g1;
      m_pp = g1;
      m_pe = e;
      m_pd = 32'd0;
      if (m_pv && !we && !e)
        m_pd = extract(t, ref_mem[a[7:0]], ref_mem[8'(a[7:0] + 1)],
                       ref_mem[8'(a[7:0] + 2)], ref_mem[8'(a[7:0] + 3)]);
      if (m_pv && we && !e) begin
        size = 1 << t;
        for (int k = 0; k < size; k++) ref_mem[8'(a[7:0] + k)] = d[8*k +: 8];
      end
      m_wait = (p1_valid && !g1) ? ((m_wait < LIM) ? m_wait + 1 : LIM) : 0;
    end
  end

  typedef struct packed {
    logic        p0v, p0we; logic [31:0] p0a, p0d; logic [2:0] p0t;
    logic        p1v, p1we; logic [31:0] p1a, p1d; logic [2:0] p1t;
    logic        rdy0, rdy1, mwe, v0, v1, e0, e1;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vt [12];

  task automatic drive(input logic v0, we0, input logic [31:0] a0, d0, input logic [2:0] t0,
                       input logic v1, we1, input logic [31:0] a1, d1, input logic [2:0] t1);
    p0_valid = v0; p0_we = we0; p0_addr = a0; p0_wdata = d0; p0_type = t0;
    p1_valid = v1; p1_we = we1; p1_addr = a1; p1_wdata = d1; p1_type = t1;
  endtask

  task automatic gen(output logic v, we, output logic [31:0] a, d, output logic [2:0] t,
                     input int pct);
    logic [2:0] lt [5];
    lt = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    v  = ($urandom_range(99) < pct);
    we = 1'($urandom_range(1));
    if ($urandom_range(7) == 0) t = 3'($urandom_range(7));
    else if (we) t = 3'($urandom_range(2));
    else t = lt[$urandom_range(4)];
    a = {25'd0, 7'($urandom_range(127))};
    if ($urandom_range(4) != 0) a[1:0] = 2'b00;
    d = $urandom;
  endtask

  logic [7:0] s_r0, s_r1, s_v0, s_v1;

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 8'd0;
      ref_mem[i] = 8'd0;
    end
    //            p0: v we addr      wdata        t   p1: v we addr     wdata        t   rdy0 rdy1 mwe v0 v1 e0 e1 rd0          rd1
    vt[0]  = '{1'b1,1'b1,32'h10,32'hDEADBEEF,3'd2, 1'b0,1'b0,32'h0, 32'h0,       3'd0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,       32'h0};
    vt[1]  = '{1'b1,1'b0,32'h10,32'h0,       3'd2, 1'b0,1'b0,32'h0, 32'h0,       3'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,       32'h0};
    vt[2]  = '{1'b1,1'b1,32'h13,32'h80,      3'd0, 1'b0,1'b0,32'h0, 32'h0,       3'd0, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF,32'h0};
    vt[3]  = '{1'b1,1'b0,32'h13,32'h0,       3'd0, 1'b0,1'b0,32'h0, 32'h0,       3'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,       32'h0};
    vt[4]  = '{1'b1,1'b0,32'h13,32'h0,       3'd4, 1'b0,1'b0,32'h0, 32'h0,       3'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'hFFFFFF80,32'h0};
    vt[5]  = '{1'b0,1'b0,32'h0, 32'h0,       3'd0, 1'b1,1'b0,32'h21,32'h0,       3'd1, 1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h00000080,32'h0};
    vt[6]  = '{1'b0,1'b0,32'h0, 32'h0,       3'd0, 1'b1,1'b0,32'h20,32'h0,       3'd6, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,32'h0,       32'h0};
    vt[7]  = '{1'b0,1'b0,32'h0, 32'h0,       3'd0, 1'b1,1'b1,32'h20,32'hFFFFFFFF,3'd3, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,32'h0,       32'h0};
    vt[8]  = '{1'b0,1'b0,32'h0, 32'h0,       3'd0, 1'b1,1'b0,32'h10,32'h0,       3'd2, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,32'h0,       32'h0};
    vt[9]  = '{1'b0,1'b0,32'h0, 32'h0,       3'd0, 1'b1,1'b1,32'h22,32'h1234,    3'd1, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,       32'h80ADBEEF};
    vt[10] = '{1'b0,1'b0,32'h0, 32'h0,       3'd0, 1'b0,1'b0,32'h0, 32'h0,       3'd0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,       32'h0};
    vt[11] = '{1'b0,1'b0,32'h0, 32'h0,       3'd0, 1'b0,1'b0,32'h0, 32'h0,       3'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,       32'h0};

    // Reset state.
    @(negedge clk);
    chk1("rst_rsp0_v", p0_rsp_valid, 1'b0);
    chk1("rst_rsp1_v", p1_rsp_valid, 1'b0);
    chk1("rst_rsp0_err", p0_rsp_err, 1'b0);
    chk32("rst_rsp1_rdata", p1_rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors: each row is one cycle of inputs and the outputs seen in that cycle.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      drive(vt[i].p0v, vt[i].p0we, vt[i].p0a, vt[i].p0d, vt[i].p0t,
            vt[i].p1v, vt[i].p1we, vt[i].p1a, vt[i].p1d, vt[i].p1t);
      @(negedge clk);
      chk1($sformatf("vec%0d_p0_ready", i), p0_ready, vt[i].rdy0);
      chk1($sformatf("vec%0d_p1_ready", i), p1_ready, vt[i].rdy1);
      chk1($sformatf("vec%0d_mem_we", i), mem_we, vt[i].mwe);
      chk1($sformatf("vec%0d_rsp0_v", i), p0_rsp_valid, vt[i].v0);
      chk1($sformatf("vec%0d_rsp1_v", i), p1_rsp_valid, vt[i].v1);
      chk1($sformatf("vec%0d_rsp0_err", i), p0_rsp_err, vt[i].e0);
      chk1($sformatf("vec%0d_rsp1_err", i), p1_rsp_err, vt[i].e1);
      chk32($sformatf("vec%0d_rsp0_rdata", i), p0_rsp_rdata, vt[i].rd0);
      chk32($sformatf("vec%0d_rsp1_rdata", i), p1_rsp_rdata, vt[i].rd1);
    end

    // Starvation: both ports loading 0x10 continuously; port 1 wins on the 5th cycle.
    s_r0 = 8'b1110_1111; s_r1 = 8'b1101_0000; s_v0 = 8'b0101_1110; s_v1 = 8'b0010_0000;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k < 6) drive(1, 0, 32'h10, 0, 3'd2, 1, 0, 32'h10, 0, 3'd2);
      else       drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0);
      @(negedge clk);
      chk1($sformatf("starve%0d_p0_ready", k), p0_ready, s_r0[k]);
      chk1($sformatf("starve%0d_p1_ready", k), p1_ready, s_r1[k]);
      chk1($sformatf("starve%0d_rsp0_v", k), p0_rsp_valid, s_v0[k]);
      chk1($sformatf("starve%0d_rsp1_v", k), p1_rsp_valid, s_v1[k]);
      if (s_v0[k]) chk32($sformatf("starve%0d_rsp0_rdata", k), p0_rsp_rdata, 32'h80ADBEEF);
      if (s_v1[k]) chk32($sformatf("starve%0d_rsp1_rdata", k), p1_rsp_rdata, 32'h80ADBEEF);
    end

    // Port 1 alone: 8 word stores then 8 back-to-back word loads.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 3'd0, 1, 1, 32'(4 * k), 32'hA5000000 | 32'(k), 3'd2);
    end
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k < 8) drive(0, 0, 0, 0, 3'd0, 1, 0, 32'(4 * k), 0, 3'd2);
      else       drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0);
      @(negedge clk);
      chk1($sformatf("burst%0d_rsp1_v", k), p1_rsp_valid, 1'b1);
      chk1($sformatf("burst%0d_rsp0_v", k), p0_rsp_valid, 1'b0);
      if (k > 0) chk32($sformatf("burst%0d_rdata", k), p1_rsp_rdata, 32'hA5000000 | 32'(k - 1));
    end

    // Reset right after a port 0 load is accepted; port 1 has been waiting two cycles.
    @(posedge clk); #1;
    drive(1, 1, 32'h40, 32'h12345678, 3'd2, 1, 0, 32'h0, 0, 3'd2);
    @(posedge clk); #1;
    drive(1, 0, 32'h40, 0, 3'd2, 1, 0, 32'h0, 0, 3'd2);
    @(negedge clk);
    chk1("rstseq_load_accepted", p0_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1, 1, 32'h44, 32'hFFFFFFFF, 3'd2, 0, 0, 0, 0, 3'd0);
    @(negedge clk);
    chk1("rstseq_rsp0_v_in_reset", p0_rsp_valid, 1'b0);
    chk1("rstseq_mem_we_in_reset", mem_we, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    s_r1 = 8'b0001_0000;
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 32'h40, 0, 3'd2, 1, 0, 32'h0, 0, 3'd2);
      @(negedge clk);
      if (k == 0) chk1("rstseq_no_stale_rsp", p0_rsp_valid, 1'b0);
      if (k == 1) chk32("rstseq_store_kept", p0_rsp_rdata, 32'h12345678);
      chk1($sformatf("rstseq%0d_p1_ready", k), p1_ready, s_r1[k]);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0);

    // Random traffic against the reference model; held requests follow the stability rule.
    @(negedge clk);
    chk_rand = 1;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (!(p0_valid && !m_acc0)) gen(p0_valid, p0_we, p0_addr, p0_wdata, p0_type, 60);
      if (!(p1_valid && !m_acc1)) gen(p1_valid, p1_we, p1_addr, p1_wdata, p1_type, 50);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0);
    @(negedge clk);
    chk_rand = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
